// File: rtl/full_adder_32b.sv
// ---------------------------------------------------------------------------
// full_adder_32b
//
// Registered binary adder with carry-in and carry-out. Computes
// {cout, sum} = a + b + c and presents the result from output flops one
// clock after the operands are sampled. Signed and unsigned operands share
// the same logic because two's-complement addition is identical; cout is
// the unsigned carry out of the top bit, and no overflow flag is produced.
//
// The combinational core is a chain of 4-bit carry-lookahead groups. Inside
// a group every carry is a flat sum-of-products of the generate/propagate
// terms and the group carry-in. Between groups the group carries ripple.
//
// Ports:
//   clk    in   1      clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset, clears sum/cout
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   c      in   1      carry-in, same weight as a[0]/b[0]
//   sum    out  WIDTH  registered sum bits of a + b + c
//   cout   out  1      registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla_group_4b
//
// One 4-bit carry-lookahead slice. Every internal carry comes straight from
// g/p/cin, so nothing ripples inside the group.
//
// Ports:
//   a, b  in   4  operand nibbles
//   cin   in   1  carry into bit 0 of the group
//   sum   out  4  sum nibble
//   cout  out 1   carry out of bit 3 of the group
// ---------------------------------------------------------------------------
module cla_group_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] carry;

  // Per-bit generate and propagate terms. The propagate term is the XOR
  // form, so it can also be used directly to form the sum bits.
  assign g = a & b;
  assign p = a ^ b;

  // The carries are expanded in full lookahead form. carry[k] is the carry
  // into bit k. carry[4] leaves the group.
  always_comb begin
    carry[0] = cin;
    carry[1] = g[0]
             | (p[0] & cin);
    carry[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
    carry[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    carry[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ carry[3:0];
  assign cout = carry[4];

endmodule

module full_adder_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // WIDTH is expected to be a multiple of 4 so the operands split evenly
  // into lookahead groups. Only 32 is used in practice.
  localparam int NUM_GROUPS = WIDTH / 4;

  logic [NUM_GROUPS:0] group_carry;
  logic [WIDTH-1:0]    sum_n;
  logic                cout_n;

  assign group_carry[0] = c;

  // The groups are chained by their carries. Group i covers operand bits
  // [4*i+3:4*i].
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
    cla_group_4b u_group (
      .a    (a[4*gi +: 4]),
      .b    (b[4*gi +: 4]),
      .cin  (group_carry[gi]),
      .sum  (sum_n[4*gi +: 4]),
      .cout (group_carry[gi+1])
    );
  end

  assign cout_n = group_carry[NUM_GROUPS];

  // These are the output registers. The inputs are sampled on every rising
  // edge, with no enable. Reset clears the outputs at once, without waiting
  // for a clock edge. Any result that is in flight at reset is dropped.
  // These flops are the only state in the design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_n;
      cout <= cout_n;
    end
  end

endmodule

// File: tb/tb_full_adder_32b.sv
// ---------------------------------------------------------------------------
// tb_full_adder_32b
//
// Self-checking bench for full_adder_32b. The expected results come from
// plain 33-bit arithmetic, and from constant values for the directed cases.
// ---------------------------------------------------------------------------
module tb_full_adder_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        c;
  logic [31:0] sum;
  logic        cout;

  int total = 0;
  int bad   = 0;

  logic [32:0] prev_exp;
  bit          prev_valid = 1'b0;

  full_adder_32b #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (sum),
    .cout  (cout)
  );

  // This is a free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // The reference model is the exact arithmetic sum of the operands and
  // the carry-in. It is computed in 33 bits, so bit 32 is the carry-out.
  function automatic logic [32:0] refAdd(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  // This task compares the DUT outputs with one expected {cout, sum} pair.
  task automatic checkOutput(input string tag, input logic [32:0] exp);
    total++;
    assert ({cout, sum} === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
             tag, sum, cout, exp[31:0], exp[32]);
    end
  endtask

  // This task drives new operands just after a falling edge. Just after the
  // inputs change, the outputs must still hold the previous result. One
  // rising edge later, they must show the new result.
  task automatic applyStimulus(input logic [31:0] na, input logic [31:0] nb,
                               input logic nc, input string tag,
                               input logic [32:0] exp);
    @(negedge clk);
    a = na;
    b = nb;
    c = nc;
    #1;
    if (prev_valid) checkOutput({tag, "/hold"}, prev_exp);
    @(posedge clk);
    #1;
    checkOutput(tag, exp);
    prev_exp   = exp;
    prev_valid = 1'b1;
  endtask

  // This function returns a random operand. About one time in four, it
  // returns one of the corner values instead.
  function automatic logic [31:0] pickOperand();
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    $display("[TB] start");

    // Hold reset with large operands while the clock runs.
    rst_n = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0001;
    c     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("reset_hold", 33'h0_0000_0000);
    end

    // On release, the first rising edge loads the pending operands.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 33'h1_0000_0000);
    prev_exp   = 33'h1_0000_0000;
    prev_valid = 1'b1;

    // These are directed adds, one result per cycle.
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, "zero",       33'h0_0000_0000);
    applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0, "one_one",    33'h0_0000_0002);
    applyStimulus(32'h0000_000F, 32'h0000_0001, 1'b0, "nibble",     33'h0_0000_0010);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, "pattern",    33'h0_2468_ACF0);
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, "alt_nocin",  33'h0_FFFF_FFFF);
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, "alt_cin",    33'h1_0000_0000);
    applyStimulus(32'hFFFF_FFF0, 32'h0000_0010, 1'b0, "upper_wrap", 33'h1_0000_0000);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "smax_inc",   33'h0_8000_0000);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "smin_dec",   33'h1_7FFF_FFFF);
    applyStimulus(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, "cin_wrap",   33'h1_0000_0001);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "cin_only",   33'h1_0000_0000);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "maximum",    33'h1_FFFF_FFFF);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, "pre_reset",  33'h0_2345_6789);

    // Assert reset between clock edges. The outputs must clear at once,
    // and they must stay clear across a rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", 33'h0_0000_0000);
    @(posedge clk);
    #1;
    checkOutput("reset_mid_hold", 33'h0_0000_0000);
    @(negedge clk);
    rst_n      = 1'b1;
    prev_exp   = refAdd(a, b, c);
    prev_valid = 1'b1;

    // Apply random operand triples back to back, with corners mixed in.
    for (int i = 0; i < 10000; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      rc = 1'($urandom_range(1));
      applyStimulus(ra, rb, rc, "random", refAdd(ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
